// File: rtl/imul_prod_accum_if.sv
// Product-stream in / group-result out bundle for the product accumulator.
// The slave modport is the accumulator's view; master is the surrounding logic.
interface imul_prod_accum_if #(
  parameter int unsigned p_nbits     = 32,
  parameter int unsigned p_cnt_nbits = 16
);
  logic                   in_val;
  logic                   in_rdy;
  logic [p_nbits-1:0]     in_msg;
  logic                   in_last;
  logic                   out_val;
  logic                   out_rdy;
  logic [p_nbits-1:0]     out_sum;
  logic [p_cnt_nbits-1:0] out_cnt;
  logic                   out_ovf;

  modport slave (
    input  in_val, in_msg, in_last, out_rdy,
    output in_rdy, out_val, out_sum, out_cnt, out_ovf
  );

  modport master (
    output in_val, in_msg, in_last, out_rdy,
    input  in_rdy, out_val, out_sum, out_cnt, out_ovf
  );
endinterface

// File: rtl/imul_prod_accum.sv
// Sums last-delimited groups of unsigned products and presents sum, term count
// and sticky carry flag; the result cycle can also accept the next group's first term.
module imul_prod_accum #(
  parameter int unsigned p_nbits     = 32,
  parameter int unsigned p_cnt_nbits = 16
) (
  input  logic               clk,
  input  logic               reset,
  imul_prod_accum_if.slave   io
);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [p_nbits-1:0]     r_acc;
  logic [p_nbits-1:0]     w_acc_nxt;
  logic [p_cnt_nbits-1:0] r_cnt;
  logic [p_cnt_nbits-1:0] w_cnt_nxt;
  logic                   r_ovf;
  logic                   w_ovf_nxt;
  logic                   w_in_rdy;
  logic                   w_out_val;
  logic [p_nbits:0]       w_sum;

  // Extra top bit captures the carry-out of the running sum
  assign w_sum = {1'b0, r_acc} + {1'b0, io.in_msg};

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    w_in_rdy    = 1'b0;
    w_out_val   = 1'b0;

    case (r_state)
      ST_ACC: begin
        w_in_rdy = 1'b1;
        if (io.in_val) begin
          w_acc_nxt = w_sum[p_nbits-1:0];
          w_cnt_nxt = r_cnt + p_cnt_nbits'(1);
          w_ovf_nxt = r_ovf | w_sum[p_nbits];
          if (io.in_last) begin
            w_state_nxt = ST_XFER;
          end
        end
      end
      ST_XFER: begin
        w_out_val = 1'b1;
        w_in_rdy  = io.out_rdy;
        // A product arriving with the result handoff opens the next group
        if (io.out_rdy) begin
          if (io.in_val) begin
            w_acc_nxt   = io.in_msg;
            w_cnt_nxt   = p_cnt_nbits'(1);
            w_ovf_nxt   = 1'b0;
            w_state_nxt = io.in_last ? ST_XFER : ST_ACC;
          end else begin
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_ovf_nxt   = 1'b0;
            w_state_nxt = ST_ACC;
          end
        end
      end
      default: begin
        w_state_nxt = ST_ACC;
      end
    endcase

    if (reset) begin
      w_in_rdy  = 1'b0;
      w_out_val = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_ACC;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign io.in_rdy  = w_in_rdy;
  assign io.out_val = w_out_val;
  assign io.out_sum = r_acc;
  assign io.out_cnt = r_cnt;
  assign io.out_ovf = r_ovf;

endmodule

// File: tb/tb_imul_prod_accum.sv
// Scoreboard bench for imul_prod_accum: a group model pushes expected results
// as products are accepted; a monitor pops and compares on each output transfer.
module tb_imul_prod_accum;

  typedef struct {
    logic [31:0] sum;
    logic [15:0] cnt;
    logic        ovf;
  } exp_t;

  logic clk;
  logic reset;
  logic rand_rdy;

  int n_checks;
  int n_fail;

  exp_t sb[$];

  logic [31:0] m_acc;
  logic [15:0] m_cnt;
  logic        m_ovf;

  imul_prod_accum_if #(.p_nbits(32), .p_cnt_nbits(16)) bus ();

  imul_prod_accum #(.p_nbits(32), .p_cnt_nbits(16)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_accept(input logic [31:0] msg, input logic last);
    logic [32:0] s;
    exp_t e;
    s     = {1'b0, m_acc} + {1'b0, msg};
    m_acc = s[31:0];
    m_cnt = m_cnt + 16'd1;
    m_ovf = m_ovf | s[32];
    if (last) begin
      e.sum = m_acc;
      e.cnt = m_cnt;
      e.ovf = m_ovf;
      sb.push_back(e);
      m_acc = '0;
      m_cnt = '0;
      m_ovf = 1'b0;
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge
  task automatic send(input logic [31:0] msg, input logic last, output int waits);
    bit done;
    done         = 1'b0;
    waits        = 0;
    bus.in_val   = 1'b1;
    bus.in_msg   = msg;
    bus.in_last  = last;
    while (!done) begin
      @(negedge clk);
      if (bus.in_rdy) begin
        @(posedge clk);
        model_accept(msg, last);
        done = 1'b1;
      end else begin
        @(posedge clk);
        waits++;
        if (waits > 200) begin
          check("send_timeout", 64'(waits), 64'd0);
          done = 1'b1;
        end
      end
      #1;
    end
  endtask

  task automatic idle(input int n);
    bus.in_val = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Random consumer back-pressure when enabled
  always begin
    @(posedge clk);
    #1;
    if (rand_rdy) bus.out_rdy = 1'($urandom_range(0, 1));
  end

  // Output monitor: every output transfer must match the head of the scoreboard
  always @(negedge clk) begin
    if (!reset && bus.out_val === 1'b1 && bus.out_rdy === 1'b1) begin
      exp_t e;
      check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out_sum", 64'(bus.out_sum), 64'(e.sum));
        check("out_cnt", 64'(bus.out_cnt), 64'(e.cnt));
        check("out_ovf", 64'(bus.out_ovf), 64'(e.ovf));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int k;
    n_checks    = 0;
    n_fail      = 0;
    m_acc       = '0;
    m_cnt       = '0;
    m_ovf       = 1'b0;
    rand_rdy    = 1'b0;
    reset       = 1'b1;
    bus.in_val  = 1'b0;
    bus.in_msg  = '0;
    bus.in_last = 1'b0;
    bus.out_rdy = 1'b1;

    // Reset behaviour
    @(negedge clk);
    check("rst_in_rdy", 64'(bus.in_rdy), 64'd0);
    check("rst_out_val", 64'(bus.out_val), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_out_val", 64'(bus.out_val), 64'd0);
    check("post_rst_in_rdy", 64'(bus.in_rdy), 64'd1);
    check("post_rst_sum", 64'(bus.out_sum), 64'd0);
    check("post_rst_cnt", 64'(bus.out_cnt), 64'd0);
    @(posedge clk); #1;

    // Basic group 3+5+7 with latency check
    send(32'd3, 1'b0, w);
    send(32'd5, 1'b0, w);
    check("basic_no_bubble", 64'(w), 64'd0);
    send(32'd7, 1'b1, w);
    bus.in_val = 1'b0;
    @(negedge clk);
    check("basic_latency_val", 64'(bus.out_val), 64'd1);
    @(posedge clk); #1;
    idle(1);

    // Carry-out, then a clean group must clear the flag
    send(32'hFFFF_FFFF, 1'b0, w);
    send(32'h0000_0002, 1'b1, w);
    idle(2);
    send(32'd4, 1'b1, w);
    idle(2);

    // Back-pressure with a pending product
    send(32'd10, 1'b0, w);
    send(32'd20, 1'b1, w);
    bus.out_rdy = 1'b0;
    bus.in_val  = 1'b1;
    bus.in_msg  = 32'd9;
    bus.in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_rdy", 64'(bus.in_rdy), 64'd0);
      check("bp_out_val", 64'(bus.out_val), 64'd1);
      check("bp_sum", 64'(bus.out_sum), 64'd30);
      check("bp_cnt", 64'(bus.out_cnt), 64'd2);
      @(posedge clk); #1;
    end
    bus.out_rdy = 1'b1;
    send(32'd9, 1'b0, w);
    check("bp_release_same_cycle", 64'(w), 64'd0);
    bus.in_val = 1'b0;
    @(negedge clk);
    check("bp_next_acc", 64'(bus.out_sum), 64'd9);
    check("bp_next_cnt", 64'(bus.out_cnt), 64'd1);
    check("bp_next_val", 64'(bus.out_val), 64'd0);
    @(posedge clk); #1;
    send(32'd1, 1'b1, w);
    idle(2);

    // Single-term streaming, one result per cycle
    for (int i = 1; i <= 4; i++) begin
      send(32'(i), 1'b1, w);
      if (i > 1) check("stream_no_stall", 64'(w), 64'd0);
    end
    bus.in_val = 1'b0;
    @(negedge clk);
    check("stream_last_val", 64'(bus.out_val), 64'd1);
    check("stream_last_sum", 64'(bus.out_sum), 64'd4);
    @(posedge clk); #1;
    idle(1);

    // Input bubbles with random back-pressure: sum of squares 1..10
    rand_rdy = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      k = $urandom_range(0, 2);
      if (k != 0) idle(k);
      send(32'(i * i), (i == 10), w);
    end
    bus.in_val = 1'b0;
    rand_rdy   = 1'b0;
    @(posedge clk); #2;
    bus.out_rdy = 1'b1;
    idle(3);

    // Reset in the middle of a group discards it
    send(32'd1, 1'b0, w);
    send(32'd2, 1'b0, w);
    reset       = 1'b1;
    bus.in_val  = 1'b1;
    bus.in_msg  = 32'd3;
    bus.in_last = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("midrst_out_val", 64'(bus.out_val), 64'd0);
      check("midrst_in_rdy", 64'(bus.in_rdy), 64'd0);
      @(posedge clk); #1;
    end
    m_acc = '0;
    m_cnt = '0;
    m_ovf = 1'b0;
    reset = 1'b0;
    bus.in_val = 1'b0;
    @(posedge clk); #1;
    send(32'd6, 1'b1, w);
    idle(1);

    // Drain the scoreboard
    for (int i = 0; i < 50 && sb.size() != 0; i++) idle(1);
    check("drain_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
